// File: rtl/matmul_drain_pkg.sv
// ---------------------------------------------------------------------------
// matmul_drain_pkg
// Shared definitions for the matmul result drain:
//   DW            - element width (signed 32-bit results)
//   drain_state_e - drain FSM states (IDLE, DRAIN)
//   calc_beats    - number of output beats needed for an M x N tile
//   beat_width    - width of the beat index (never less than 1 bit)
// ---------------------------------------------------------------------------
package matmul_drain_pkg;

    localparam int DW = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_e;

    // ceil(M*N / LANES)
    function automatic int calc_beats(input int m, input int n, input int lanes);
        return (m * n + lanes - 1) / lanes;
    endfunction

    function automatic int beat_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/matmul_drain_tile_buf.sv
// ---------------------------------------------------------------------------
// matmul_drain_tile_buf
// One M x N tile register array plus a LANES-wide read slice.
// Elements are stored flat in row-major order (k = i*N + j); beat b reads
// elements b*LANES .. b*LANES+LANES-1, lane 0 in the LSBs. Lane positions
// past the end of the tile read as zero.
//
// Ports:
//   clk      in   clock
//   load     in   capture the whole tile d on this rising edge
//   clear    in   synchronous clear (wins over load)
//   d        in   M x N signed result tile
//   beat_idx in   beat to present on slice
//   slice    out  LANES*DW bits for the selected beat
// ---------------------------------------------------------------------------
module matmul_drain_tile_buf
    import matmul_drain_pkg::*;
#(
    parameter  int M     = 2,
    parameter  int N     = 2,
    parameter  int LANES = 1,
    localparam int BEATS = calc_beats(M, N, LANES),
    localparam int BW    = beat_width(BEATS)
) (
    input  logic                 clk,
    input  logic                 load,
    input  logic                 clear,
    input  logic signed [DW-1:0] d [M][N],
    input  logic [BW-1:0]        beat_idx,
    output logic [LANES*DW-1:0]  slice
);

    localparam int ELEMS = M * N;
    localparam int PADW  = BEATS * LANES * DW;

    logic [ELEMS*DW-1:0] mem;
    logic [PADW-1:0]     padded;

    always_ff @(posedge clk) begin
        if (clear) begin
            mem <= '0;
        end else if (load) begin
            for (int i = 0; i < M; i++) begin
                for (int j = 0; j < N; j++) begin
                    mem[(i*N + j)*DW +: DW] <= d[i][j];
                end
            end
        end
    end

    // The tile is zero-extended to a whole number of beats so the last beat's
    // unused lanes come out as zero; the beat is then picked by a mux over
    // constant offsets.
    always_comb begin
        padded = '0;
        padded[ELEMS*DW-1:0] = mem;
        slice = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (beat_idx == BW'(b)) begin
                slice = padded[b*LANES*DW +: LANES*DW];
            end
        end
    end

endmodule

// File: rtl/matmul_result_drain.sv
// ---------------------------------------------------------------------------
// matmul_result_drain
// Accepts one M x N tile of signed 32-bit results from the matmul core over
// valid_i/ready_o and streams it out row-major, LANES elements per beat, on
// data_o/valid_o/ready_i with last_o marking the final beat of each tile.
//
// Handshake rule (both sides): a transfer happens on a rising edge where
// valid and ready are both 1. A source holding valid keeps its payload
// stable until that edge; valid_o never drops without a transfer, and
// ready_o depends only on registered state.
//
// Ports:
//   clk_i       in   clock
//   rst_i       in   synchronous active-high reset
//   D_i         in   M x N result tile (sampled only on a tile accept)
//   valid_i     in   tile valid
//   ready_o     out  tile accept
//   data_o      out  output beat, lane 0 in the LSBs, zero when idle
//   valid_o     out  beat valid
//   ready_i     in   downstream accept
//   last_o      out  final beat of the tile
//   beat_idx_o  out  index of the current beat within the tile
//
// Build option MATMUL_DRAIN_DOUBLE_BUFFER_EN: adds a second tile buffer so
// the next tile can be accepted while the current one drains, and drains
// back-to-back tiles with no idle cycle between them.
// ---------------------------------------------------------------------------
module matmul_result_drain
    import matmul_drain_pkg::*;
#(
    parameter  int M     = 2,
    parameter  int N     = 2,
    parameter  int LANES = 1,
    localparam int BEATS = calc_beats(M, N, LANES),
    localparam int BW    = beat_width(BEATS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic signed [DW-1:0] D_i [M][N],
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [LANES*DW-1:0]  data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 last_o,
    output logic [BW-1:0]        beat_idx_o
);

    localparam logic [BW-1:0] LAST_IDX = BW'(BEATS - 1);

    drain_state_e         state_q, state_d;
    logic [BW-1:0]        cnt_q, cnt_d;
    logic                 tile_acc;
    logic                 beat_hs;
    logic                 last_hs;
    logic [LANES*DW-1:0]  slice;

    assign tile_acc = valid_i && ready_o;
    assign beat_hs  = valid_o && ready_i;
    assign last_hs  = beat_hs && (cnt_q == LAST_IDX);

    assign valid_o    = (state_q == DRAIN);
    assign last_o     = (state_q == DRAIN) && (cnt_q == LAST_IDX);
    assign beat_idx_o = cnt_q;
    assign data_o     = valid_o ? slice : '0;

`ifdef MATMUL_DRAIN_DOUBLE_BUFFER_EN
    // Two physical buffers; rd_sel_q names the one being drained ("active"),
    // the other is the shadow. Promoting the shadow is a pointer flip rather
    // than a copy.
    logic       shadow_full_q, shadow_full_d;
    logic       rd_sel_q, rd_sel_d;
    logic [1:0] load;
    logic [LANES*DW-1:0] slice0, slice1;

    assign ready_o = !shadow_full_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shadow_full_d = shadow_full_q;
        rd_sel_d      = rd_sel_q;
        load          = '0;
        case (state_q)
            IDLE: begin
                if (tile_acc) begin
                    state_d        = DRAIN;
                    cnt_d          = '0;
                    load[rd_sel_q] = 1'b1;
                end
            end
            DRAIN: begin
                if (last_hs) begin
                    cnt_d = '0;
                    if (shadow_full_q) begin
                        // shadow becomes active; ready_o was 0 so no accept here
                        rd_sel_d      = ~rd_sel_q;
                        shadow_full_d = 1'b0;
                    end else if (tile_acc) begin
                        // the drained buffer is free at this edge: load it directly
                        load[rd_sel_q] = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (beat_hs) begin
                        cnt_d = cnt_q + BW'(1);
                    end
                    if (tile_acc) begin
                        load[~rd_sel_q] = 1'b1;
                        shadow_full_d   = 1'b1;
                    end
                end
            end
        endcase
    end

    matmul_drain_tile_buf #(.M(M), .N(N), .LANES(LANES)) u_buf0 (
        .clk      (clk_i),
        .load     (load[0]),
        .clear    (rst_i),
        .d        (D_i),
        .beat_idx (cnt_q),
        .slice    (slice0)
    );

    matmul_drain_tile_buf #(.M(M), .N(N), .LANES(LANES)) u_buf1 (
        .clk      (clk_i),
        .load     (load[1]),
        .clear    (rst_i),
        .d        (D_i),
        .beat_idx (cnt_q),
        .slice    (slice1)
    );

    assign slice = rd_sel_q ? slice1 : slice0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            shadow_full_q <= 1'b0;
            rd_sel_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shadow_full_q <= shadow_full_d;
            rd_sel_q      <= rd_sel_d;
        end
    end
`else
    // Single buffer: a tile is only accepted from IDLE, which leaves one idle
    // cycle between the last beat of a tile and the accept of the next.
    assign ready_o = (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (tile_acc) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                if (last_hs) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (beat_hs) begin
                    cnt_d = cnt_q + BW'(1);
                end
            end
        endcase
    end

    matmul_drain_tile_buf #(.M(M), .N(N), .LANES(LANES)) u_buf0 (
        .clk      (clk_i),
        .load     (tile_acc),
        .clear    (rst_i),
        .d        (D_i),
        .beat_idx (cnt_q),
        .slice    (slice)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_matmul_result_drain.sv
// ---------------------------------------------------------------------------
// tb_matmul_result_drain
// Two instances share clock and reset: dut1 (2x2, LANES=1, 4 beats/tile) and
// dut3 (2x2, LANES=3, 2 beats/tile). A scoreboard built from the row-major
// beat rule holds the expected beats of every accepted tile; directed
// scenarios check exact cycle timing, and a randomized run stresses both
// instances with random tiles and random downstream back-pressure.
// ---------------------------------------------------------------------------
module tb_matmul_result_drain;

`ifdef MATMUL_DRAIN_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    typedef logic [31:0] tile_t [4];

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- dut1: LANES=1 ----------------
    logic signed [31:0] d1 [2][2];
    logic        in_valid1, in_ready1;
    logic [31:0] out_data1;
    logic        out_valid1, out_ready1, out_last1;
    logic [1:0]  out_idx1;

    matmul_result_drain #(.M(2), .N(2), .LANES(1)) dut1 (
        .clk_i      (clk),
        .rst_i      (rst),
        .D_i        (d1),
        .valid_i    (in_valid1),
        .ready_o    (in_ready1),
        .data_o     (out_data1),
        .valid_o    (out_valid1),
        .ready_i    (out_ready1),
        .last_o     (out_last1),
        .beat_idx_o (out_idx1)
    );

    // ---------------- dut3: LANES=3 ----------------
    logic signed [31:0] d3 [2][2];
    logic        in_valid3, in_ready3;
    logic [95:0] out_data3;
    logic        out_valid3, out_ready3, out_last3;
    logic [0:0]  out_idx3;

    matmul_result_drain #(.M(2), .N(2), .LANES(3)) dut3 (
        .clk_i      (clk),
        .rst_i      (rst),
        .D_i        (d3),
        .valid_i    (in_valid3),
        .ready_o    (in_ready3),
        .data_o     (out_data3),
        .valid_o    (out_valid3),
        .ready_i    (out_ready3),
        .last_o     (out_last3),
        .beat_idx_o (out_idx3)
    );

    int n_cmp = 0;
    int n_err = 0;

    // scoreboard entries: {beat_idx, last, data}
    logic [34:0] exp1_q[$];
    logic [97:0] exp3_q[$];
    bit          stall1, stall3;
    logic [34:0] held1;
    logic [97:0] held3;
    bit          done1, done3;

    // ---------------- reference model ----------------
    // Beat b carries flat elements b*lanes .. b*lanes+lanes-1; missing ones are 0.
    function automatic logic [95:0] beat_bits(input tile_t e, input int lanes, input int b);
        logic [95:0] r;
        r = '0;
        for (int l = 0; l < lanes; l++) begin
            if (b * lanes + l < 4) r[l*32 +: 32] = e[b*lanes + l];
        end
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a tile on dut1 until accepted; returns just after the accept edge.
    task automatic send1(input tile_t e);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 4; k++) d1[k/2][k%2] = e[k];
        in_valid1 = 1'b1;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            ok = in_ready1;
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL accept1: ready_o stayed 0 for 100 cycles, want 1");
        end
        step();
        in_valid1 = 1'b0;
        for (int k = 0; k < 4; k++) d1[k/2][k%2] = $urandom();
    endtask

    task automatic send3(input tile_t e);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 4; k++) d3[k/2][k%2] = e[k];
        in_valid3 = 1'b1;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            ok = in_ready3;
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL accept3: ready_o stayed 0 for 100 cycles, want 1");
        end
        step();
        in_valid3 = 1'b0;
        for (int k = 0; k < 4; k++) d3[k/2][k%2] = $urandom();
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic run_monitor();
        tile_t       e;
        logic [95:0] bb;
        logic [34:0] obs1, w1;
        logic [97:0] obs3, w3;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp1_q.delete();
                exp3_q.delete();
                stall1 = 1'b0;
                stall3 = 1'b0;
            end else begin
                obs1 = {out_idx1, out_last1, out_data1};
                obs3 = {out_idx3, out_last3, out_data3};
                // a stalled beat must still be there, unchanged
                if (stall1) begin
                    n_cmp++;
                    if (!out_valid1 || obs1 !== held1) begin
                        n_err++;
                        $display("FAIL hold1: got valid=%0b beat=%h want valid=1 beat=%h", out_valid1, obs1, held1);
                    end
                end
                if (stall3) begin
                    n_cmp++;
                    if (!out_valid3 || obs3 !== held3) begin
                        n_err++;
                        $display("FAIL hold3: got valid=%0b beat=%h want valid=1 beat=%h", out_valid3, obs3, held3);
                    end
                end
                if (out_valid1 && out_ready1) begin
                    n_cmp++;
                    if (exp1_q.size() == 0) begin
                        n_err++;
                        $display("FAIL beat1: got unexpected beat %h want no beat", obs1);
                    end else begin
                        w1 = exp1_q.pop_front();
                        if (obs1 !== w1) begin
                            n_err++;
                            $display("FAIL beat1: got %h want %h", obs1, w1);
                        end
                    end
                end
                if (out_valid3 && out_ready3) begin
                    n_cmp++;
                    if (exp3_q.size() == 0) begin
                        n_err++;
                        $display("FAIL beat3: got unexpected beat %h want no beat", obs3);
                    end else begin
                        w3 = exp3_q.pop_front();
                        if (obs3 !== w3) begin
                            n_err++;
                            $display("FAIL beat3: got %h want %h", obs3, w3);
                        end
                    end
                end
                // tile accepted at the coming edge: queue its beats
                if (in_valid1 && in_ready1) begin
                    for (int k = 0; k < 4; k++) e[k] = d1[k/2][k%2];
                    for (int b = 0; b < 4; b++) begin
                        bb = beat_bits(e, 1, b);
                        exp1_q.push_back({2'(b), (b == 3), bb[31:0]});
                    end
                end
                if (in_valid3 && in_ready3) begin
                    for (int k = 0; k < 4; k++) e[k] = d3[k/2][k%2];
                    for (int b = 0; b < 2; b++) begin
                        bb = beat_bits(e, 3, b);
                        exp3_q.push_back({1'(b), (b == 1), bb});
                    end
                end
                stall1 = out_valid1 && !out_ready1;
                stall3 = out_valid3 && !out_ready3;
                held1  = obs1;
                held3  = obs3;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        in_valid1 = 1'b0; in_valid3 = 1'b0;
        out_ready1 = 1'b1; out_ready3 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            d1[k/2][k%2] = 32'(k + 1);
            d3[k/2][k%2] = 32'(k + 1);
        end
        repeat (2) step();
        // tile offered in the last reset cycle must be ignored
        in_valid1 = 1'b1; in_valid3 = 1'b1;
        step();
        rst = 1'b0; in_valid1 = 1'b0; in_valid3 = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_valid1 !== 1'b0) begin n_err++; $display("FAIL rst_valid1: got %b want 0", out_valid1); end
        n_cmp++; if (out_last1 !== 1'b0) begin n_err++; $display("FAIL rst_last1: got %b want 0", out_last1); end
        n_cmp++; if (out_idx1 !== 2'd0) begin n_err++; $display("FAIL rst_idx1: got %0d want 0", out_idx1); end
        n_cmp++; if (out_data1 !== 32'd0) begin n_err++; $display("FAIL rst_data1: got %h want 0", out_data1); end
        n_cmp++; if (in_ready1 !== 1'b1) begin n_err++; $display("FAIL rst_ready1: got %b want 1", in_ready1); end
        n_cmp++; if (out_valid3 !== 1'b0) begin n_err++; $display("FAIL rst_valid3: got %b want 0", out_valid3); end
        n_cmp++; if (out_data3 !== 96'd0) begin n_err++; $display("FAIL rst_data3: got %h want 0", out_data3); end
        n_cmp++; if (in_ready3 !== 1'b1) begin n_err++; $display("FAIL rst_ready3: got %b want 1", in_ready3); end
        step();
    endtask

    task automatic test_basic();
        tile_t       t;
        logic [95:0] bb;
        logic [35:0] obs, want;
        t = '{32'd1, 32'd2, 32'd3, 32'd4};
        out_ready1 = 1'b1;
        send1(t);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bb   = beat_bits(t, 1, c);
            obs  = {out_valid1, out_last1, out_idx1, out_data1};
            want = {1'b1, (c == 3), 2'(c), bb[31:0]};
            n_cmp++; if (obs !== want) begin n_err++; $display("FAIL basic_beat%0d: got %h want %h", c, obs, want); end
            n_cmp++; if (in_ready1 !== DB) begin n_err++; $display("FAIL basic_ready_drain: got %b want %b", in_ready1, DB); end
        end
        @(negedge clk);
        n_cmp++; if (out_valid1 !== 1'b0) begin n_err++; $display("FAIL basic_bubble_valid: got %b want 0", out_valid1); end
        n_cmp++; if (in_ready1 !== 1'b1) begin n_err++; $display("FAIL basic_ready_after: got %b want 1", in_ready1); end
        step();
    endtask

    task automatic test_stall();
        tile_t       t;
        logic [35:0] obs, want;
        t = '{32'd1, 32'd2, 32'd3, 32'd4};
        out_ready1 = 1'b1;
        send1(t);
        @(negedge clk);
        step();
        out_ready1 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            obs  = {out_valid1, out_last1, out_idx1, out_data1};
            want = {1'b1, 1'b0, 2'd1, 32'd2};
            n_cmp++; if (obs !== want) begin n_err++; $display("FAIL stall_beat1_c%0d: got %h want %h", c, obs, want); end
            if (c == 2) begin
                step();
                out_ready1 = 1'b1;
            end
        end
        for (int b = 2; b < 4; b++) begin
            @(negedge clk);
            obs  = {out_valid1, out_last1, out_idx1, out_data1};
            want = {1'b1, (b == 3), 2'(b), 32'(b + 1)};
            n_cmp++; if (obs !== want) begin n_err++; $display("FAIL stall_after_beat%0d: got %h want %h", b, obs, want); end
        end
        repeat (2) step();
    endtask

    task automatic test_lanes3();
        tile_t       t;
        logic [98:0] obs, want;
        t = '{32'd1, 32'hFFFF_FFFF, 32'd3, 32'd4};
        out_ready3 = 1'b1;
        send3(t);
        @(negedge clk);
        obs  = {out_valid3, out_last3, out_idx3, out_data3};
        want = {1'b1, 1'b0, 1'b0, 32'd3, 32'hFFFF_FFFF, 32'd1};
        n_cmp++; if (obs !== want) begin n_err++; $display("FAIL lanes3_beat0: got %h want %h", obs, want); end
        @(negedge clk);
        obs  = {out_valid3, out_last3, out_idx3, out_data3};
        want = {1'b1, 1'b1, 1'b1, 32'd0, 32'd0, 32'd4};
        n_cmp++; if (obs !== want) begin n_err++; $display("FAIL lanes3_beat1: got %h want %h", obs, want); end
        @(negedge clk);
        n_cmp++; if (out_valid3 !== 1'b0) begin n_err++; $display("FAIL lanes3_end: got valid %b want 0", out_valid3); end
        step();
    endtask

    task automatic test_reset_mid();
        tile_t       t;
        logic [35:0] obs, want;
        t = '{32'd1, 32'd2, 32'd3, 32'd4};
        out_ready1 = 1'b1;
        send1(t);
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (out_idx1 !== 2'd1) begin n_err++; $display("FAIL rmid_idx: got %0d want 1", out_idx1); end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_valid1 !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b want 0", out_valid1); end
        n_cmp++; if (out_last1 !== 1'b0) begin n_err++; $display("FAIL rmid_last: got %b want 0", out_last1); end
        n_cmp++; if (in_ready1 !== 1'b1) begin n_err++; $display("FAIL rmid_ready: got %b want 1", in_ready1); end
        step();
        t = '{32'd9, 32'd8, 32'd7, 32'd6};
        send1(t);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            obs  = {out_valid1, out_last1, out_idx1, out_data1};
            want = {1'b1, (c == 3), 2'(c), t[c]};
            n_cmp++; if (obs !== want) begin n_err++; $display("FAIL rmid_fresh_beat%0d: got %h want %h", c, obs, want); end
        end
        repeat (2) step();
    endtask

    task automatic test_back_to_back();
        tile_t a, b;
        logic  tv [10];
        logic  tr [10];
        logic  tl [10];
        logic [31:0] td [10];
        int    gap;
        logic  exp_rdy [10];
        logic  exp_v, exp_l;
        logic [31:0] exp_d;
        a = '{32'd1, 32'd2, 32'd3, 32'd4};
        b = '{32'd5, 32'd6, 32'd7, 32'd8};
        // zero bubble with a shadow buffer, one idle cycle without
        gap = DB ? 0 : 1;
        if (DB) exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        else    exp_rdy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        out_ready1 = 1'b1;
        send1(a);
        fork
            send1(b);
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                tv[c] = out_valid1; td[c] = out_data1; tl[c] = out_last1; tr[c] = in_ready1;
            end
        join
        for (int c = 0; c < 10; c++) begin
            exp_v = 1'b0; exp_l = 1'b0; exp_d = '0;
            if (c < 4) begin
                exp_v = 1'b1; exp_d = a[c]; exp_l = (c == 3);
            end else if (c >= 4 + gap && c < 8 + gap) begin
                exp_v = 1'b1; exp_d = b[c-4-gap]; exp_l = (c == 7 + gap);
            end
            n_cmp++; if (tv[c] !== exp_v) begin n_err++; $display("FAIL b2b_valid_c%0d: got %b want %b", c, tv[c], exp_v); end
            n_cmp++; if (tr[c] !== exp_rdy[c]) begin n_err++; $display("FAIL b2b_ready_c%0d: got %b want %b", c, tr[c], exp_rdy[c]); end
            if (exp_v) begin
                n_cmp++; if (td[c] !== exp_d || tl[c] !== exp_l) begin n_err++; $display("FAIL b2b_beat_c%0d: got data=%0d last=%b want data=%0d last=%b", c, td[c], tl[c], exp_d, exp_l); end
            end
        end
        step();
    endtask

    task automatic test_random();
        done1 = 1'b0;
        done3 = 1'b0;
        fork
            begin
                tile_t t;
                for (int n = 0; n < 20; n++) begin
                    for (int k = 0; k < 4; k++) t[k] = $urandom();
                    repeat ($urandom_range(0, 2)) step();
                    send1(t);
                end
                done1 = 1'b1;
            end
            begin
                tile_t t;
                for (int n = 0; n < 20; n++) begin
                    for (int k = 0; k < 4; k++) t[k] = $urandom();
                    repeat ($urandom_range(0, 2)) step();
                    send3(t);
                end
                done3 = 1'b1;
            end
            begin
                while (!(done1 && done3)) begin
                    step();
                    out_ready1 = ($urandom_range(0, 3) != 0);
                    out_ready3 = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready1 = 1'b1;
        out_ready3 = 1'b1;
        begin
            bit drained;
            drained = 1'b0;
            for (int c = 0; c < 200 && !drained; c++) begin
                @(negedge clk);
                drained = (exp1_q.size() == 0) && (exp3_q.size() == 0) && !out_valid1 && !out_valid3;
            end
            n_cmp++;
            if (!drained) begin
                n_err++;
                $display("FAIL rand_drain: got %0d/%0d beats outstanding want 0/0", exp1_q.size(), exp3_q.size());
            end
        end
        step();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        fork
            run_monitor();
        join_none
        test_basic();
        test_stall();
        test_lanes3();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
